// File: rtl/branch_pkg.sv
// Shared types for the branch resolution unit: comparator select encoding and funct3 decode.
// Latency: none (types, constants and a pure function only).
// Backpressure: not applicable.
package branch_pkg;

    typedef enum logic [3:0] {
        CMP_EQ   = 4'd0,
        CMP_NE   = 4'd1,
        CMP_LT   = 4'd2,
        CMP_LTU  = 4'd3,
        CMP_GE   = 4'd4,
        CMP_GEU  = 4'd5,
        CMP_NONE = 4'd15
    } cmp_select_e;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // 010/011 are not branches and map to CMP_NONE.
    function automatic cmp_select_e funct3_to_sel(input logic [2:0] f3);
        cmp_select_e sel;
        case (f3)
            F3_BEQ:  sel = CMP_EQ;
            F3_BNE:  sel = CMP_NE;
            F3_BLT:  sel = CMP_LT;
            F3_BGE:  sel = CMP_GE;
            F3_BLTU: sel = CMP_LTU;
            F3_BGEU: sel = CMP_GEU;
            default: sel = CMP_NONE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/branch_compare.sv
// Combinational branch comparator selected by an encoded compare select.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; result follows inputs.
// Ports: i_a/i_b operands, i_sel compare select, o_result 1 = condition true (0 for CMP_NONE).
module branch_compare
    import branch_pkg::*;
#(
    parameter int dataWidth   = 32,
    parameter int selectWidth = 4
) (
    input  logic [dataWidth-1:0]   i_a,
    input  logic [dataWidth-1:0]   i_b,
    input  logic [selectWidth-1:0] i_sel,
    output logic                   o_result
);

    cmp_select_e w_sel;

    assign w_sel = cmp_select_e'(4'(i_sel));

    always_comb begin
        o_result = 1'b0;
        case (w_sel)
            CMP_EQ:  o_result = (i_a == i_b);
            CMP_NE:  o_result = (i_a != i_b);
            CMP_LT:  o_result = ($signed(i_a) <  $signed(i_b));
            CMP_GE:  o_result = ($signed(i_a) >= $signed(i_b));
            CMP_LTU: o_result = (i_a <  i_b);
            CMP_GEU: o_result = (i_a >= i_b);
            default: o_result = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_resolver.sv
// Two-stage branch resolver: decode funct3 in S1, compare and form taken/target/mispredict into S2.
// Latency: accepted at edge N, result registered at edge N+1 and consumable from edge N+2.
// Backpressure: valid/ready; S2 holds while out_ready=0, S1 then holds and in_ready drops.
// Ports: in_* request, out_* result, redirect_* one-cycle mispredict pulse, *_count saturating stats.
module branch_resolver
    import branch_pkg::*;
#(
    parameter int dataWidth    = 32,
    parameter int selectWidth  = 4,
    parameter int counterWidth = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [2:0]              in_funct3,
    input  logic [dataWidth-1:0]    in_rs1,
    input  logic [dataWidth-1:0]    in_rs2,
    input  logic [dataWidth-1:0]    in_pc,
    input  logic [dataWidth-1:0]    in_imm,
    input  logic                    in_pred_taken,
    input  logic                    flush,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_taken,
    output logic [dataWidth-1:0]    out_target,
    output logic                    out_mispredict,
    output logic                    out_illegal,
    output logic                    redirect_valid,
    output logic [dataWidth-1:0]    redirect_pc,
    output logic [counterWidth-1:0] branch_count,
    output logic [counterWidth-1:0] taken_count,
    output logic [counterWidth-1:0] mispredict_count
);

    // S1 state
    logic                    r_s1_valid;
    cmp_select_e             r_s1_sel;
    logic [dataWidth-1:0]    r_s1_rs1, r_s1_rs2, r_s1_pc, r_s1_imm;
    logic                    r_s1_pred;

    // S2 state
    logic                    r_s2_valid;
    logic                    r_out_taken, r_out_mispredict, r_out_illegal;
    logic [dataWidth-1:0]    r_out_target;
    logic                    r_redirect_valid;
    logic [counterWidth-1:0] r_branch_count, r_taken_count, r_mispredict_count;

    logic                    w_s2_advance, w_s1_advance, w_s2_load;
    logic                    w_cmp, w_illegal, w_taken, w_mis;
    logic [dataWidth-1:0]    w_target;
    logic [selectWidth-1:0]  w_sel;

    function automatic logic [counterWidth-1:0] sat_inc(input logic [counterWidth-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign w_s2_advance = !r_s2_valid || out_ready;
    assign w_s1_advance = !r_s1_valid || w_s2_advance;
    assign in_ready     = w_s1_advance;
    assign w_s2_load    = r_s1_valid && w_s2_advance;

    assign w_sel = selectWidth'(r_s1_sel);

    branch_compare #(
        .dataWidth   (dataWidth),
        .selectWidth (selectWidth)
    ) u_cmp (
        .i_a      (r_s1_rs1),
        .i_b      (r_s1_rs2),
        .i_sel    (w_sel),
        .o_result (w_cmp)
    );

    assign w_illegal = (r_s1_sel == CMP_NONE);
    assign w_taken   = w_cmp && !w_illegal;
    // Addition wraps modulo 2^dataWidth by construction.
    assign w_target  = w_taken ? (r_s1_pc + r_s1_imm) : (r_s1_pc + dataWidth'(4));
    assign w_mis     = !w_illegal && (w_taken != r_s1_pred);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_valid         <= 1'b0;
            r_s1_sel           <= CMP_NONE;
            r_s1_rs1           <= '0;
            r_s1_rs2           <= '0;
            r_s1_pc            <= '0;
            r_s1_imm           <= '0;
            r_s1_pred          <= 1'b0;
            r_s2_valid         <= 1'b0;
            r_out_taken        <= 1'b0;
            r_out_mispredict   <= 1'b0;
            r_out_illegal      <= 1'b0;
            r_out_target       <= '0;
            r_redirect_valid   <= 1'b0;
            r_branch_count     <= '0;
            r_taken_count      <= '0;
            r_mispredict_count <= '0;
        end else if (flush) begin
            // Kill everything in flight, including a request handshaking this edge.
            r_s1_valid       <= 1'b0;
            r_s2_valid       <= 1'b0;
            r_redirect_valid <= 1'b0;
        end else begin
            // Pulse only on the load edge, so a stalled S2 entry cannot re-fire.
            r_redirect_valid <= w_s2_load && w_mis;
            if (w_s1_advance) begin
                r_s1_valid <= in_valid;
                if (in_valid) begin
                    r_s1_sel  <= funct3_to_sel(in_funct3);
                    r_s1_rs1  <= in_rs1;
                    r_s1_rs2  <= in_rs2;
                    r_s1_pc   <= in_pc;
                    r_s1_imm  <= in_imm;
                    r_s1_pred <= in_pred_taken;
                end
            end
            if (w_s2_advance) begin
                r_s2_valid <= r_s1_valid;
            end
            if (w_s2_load) begin
                r_out_taken      <= w_taken;
                r_out_target     <= w_target;
                r_out_mispredict <= w_mis;
                r_out_illegal    <= w_illegal;
                if (!w_illegal) r_branch_count     <= sat_inc(r_branch_count);
                if (w_taken)    r_taken_count      <= sat_inc(r_taken_count);
                if (w_mis)      r_mispredict_count <= sat_inc(r_mispredict_count);
            end
        end
    end

    assign out_valid        = r_s2_valid;
    assign out_taken        = r_out_taken;
    assign out_target       = r_out_target;
    assign out_mispredict   = r_out_mispredict;
    assign out_illegal      = r_out_illegal;
    assign redirect_valid   = r_redirect_valid;
    assign redirect_pc      = r_out_target;
    assign branch_count     = r_branch_count;
    assign taken_count      = r_taken_count;
    assign mispredict_count = r_mispredict_count;

endmodule

// File: doc/branch_resolver.md
# branch_resolver

Two-stage pipelined branch resolution unit for the RISC-V core; it consumes a decoded conditional branch and drives the shared comparator with an encoded compare select. It produces the taken decision, next PC, and a misprediction redirect. It sits between decode/issue and the fetch redirect path, and keeps saturating branch statistics counters.

## Interface
Parameters:
- dataWidth, 32, operand/PC width
- selectWidth, 4, comparator select width
- counterWidth, 32, statistics counter width

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- in_valid  in  1  branch request valid
- in_ready  out  1  request accepted when in_valid && in_ready
- in_funct3  in  3  RISC-V branch funct3
- in_rs1, in_rs2  in  dataWidth  operands
- in_pc  in  dataWidth  branch PC
- in_imm  in  dataWidth  sign-extended B-immediate
- in_pred_taken  in  1  fetch prediction
- flush  in  1  synchronous pipeline kill
- out_valid  out  1  result valid
- out_ready  in  1  result consumed when out_valid && out_ready
- out_taken  out  1  resolved direction
- out_target  out  dataWidth  resolved next PC
- out_mispredict  out  1  out_taken != prediction
- out_illegal  out  1  funct3 not a branch
- redirect_valid  out  1  one-cycle redirect pulse
- redirect_pc  out  dataWidth  redirect address
- branch_count, taken_count, mispredict_count  out  counterWidth  saturating statistics

## Operation
- Funct3 encoding to compare select: 000→CMP_EQ(0), 001→CMP_NE(1), 100→CMP_LT(2), 110→CMP_LTU(3), 101→CMP_GE(4), 111→CMP_GEU(5); 010/011 → illegal, select CMP_NONE(15), comparator returns 0.
- LT/GE signed, LTU/GEU unsigned; GE true on equality.
- Stage S1 registers the accepted request and its encoded select. Stage S2 registers the comparator result and the derived outputs.
- Target = taken ? pc+imm : pc+4, truncated modulo 2^dataWidth (wrap-around legal, no fault).
- Illegal: out_illegal=1, out_taken=0, target=pc+4, mispredict=0, no redirect, no counter update.
- mispredict = taken XOR pred_taken. redirect_pc = out_target.
- Counters update when an entry loads into S2: branch_count+1 (legal only), taken_count+1 if taken, mispredict_count+1 if mispredict. Each saturates at all-ones.

## Timing
- Reset: s1_valid, s2_valid, out_*, redirect_valid, counters all 0. in_ready=1 (combinational from empty S1).
- Latency: request accepted at edge N → out_valid at edge N+2.
- s2_advance = !s2_valid || out_ready; s1_advance = !s1_valid || s2_advance; in_ready = s1_advance. Throughput one per cycle with no bubbles when out_ready=1.
- out_* hold stable while out_valid && !out_ready.
- redirect_valid is high for exactly the one cycle following the edge on which a mispredicting entry loads into S2. It is independent of out_ready and never repeats while stalled.
- flush=1: next edge clears s1_valid and s2_valid. A request accepted on the same edge is dropped. No redirect and no counter update for dropped or cleared entries. flush has priority over all loads.
- Reset mid-operation: in-flight entries are lost; any redirect pulse in progress deasserts immediately.

## Structure
- Package branch_pkg: cmp_select_e enum (CMP_EQ..CMP_GEU, CMP_NONE), funct3 constants, and a function mapping funct3 to cmp_select_e.
- Sub-module branch_compare: combinational comparator, inputs A, B, select, 1-bit result, instanced between S1 and S2.

## Test plan
- Reset then BEQ rs1=rs2=5, pc=0x100, imm=0x20, pred=0 → 2 cycles later out_taken=1, target=0x120, mispredict=1, redirect_valid one cycle with redirect_pc=0x120, branch/taken/mispredict counts=1.
- BLT rs1=0xFFFFFFFF, rs2=1 → taken. BLTU with the same operands → not taken, target=pc+4. BGE with equal operands → taken.
- Back-to-back 4 branches with out_ready=0 for 3 cycles → in_ready drops after S1 and S2 fill, outputs stable, no loss or duplication, single redirect per mispredicting entry.
- funct3=010 → out_illegal=1, taken=0, no redirect, counters unchanged.
- flush on the cycle a mispredicting entry sits in S1 and another is accepted → both vanish, no redirect, counters unchanged.
- Counters preloaded near max (counterWidth=4 build): 20 taken mispredicts → all counters hold at 15. pc=0xFFFFFFFC not taken → target=0x00000000.
